// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the MIPS ALU controller with multiply/divide unit.
// The divide datapath is present only when MDU_DIV_EN is defined.
package alu_ctrl_pkg;

    // ALUOp classes produced by the main decoder
    localparam logic [2:0] ALUOP_MEM   = 3'd0;
    localparam logic [2:0] ALUOP_BEQ   = 3'd1;
    localparam logic [2:0] ALUOP_RTYPE = 3'd2;
    localparam logic [2:0] ALUOP_ADDI  = 3'd3;
    localparam logic [2:0] ALUOP_SLTI  = 3'd4;
    localparam logic [2:0] ALUOP_J     = 3'd5;
    localparam logic [2:0] ALUOP_ANDI  = 3'd6;
    localparam logic [2:0] ALUOP_ORI   = 3'd7;

    // R-type funct field values
    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_JR    = 6'b001000;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    // ALU operation select codes
    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_OR   = 4'b0001;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_SUB  = 4'b0110;
    localparam logic [3:0] CTRL_SLT  = 4'b0111;
    localparam logic [3:0] CTRL_NOR  = 4'b1100;
    localparam logic [3:0] CTRL_MFHI = 4'b1000;
    localparam logic [3:0] CTRL_MFLO = 4'b1001;

    typedef enum logic [1:0] {IDLE, ITER, FIX} md_state_e;

    typedef enum logic [1:0] {MUL, MULU, DIV, DIVU} md_kind_e;

    // Signed kinds operate on magnitudes and fix the sign at the end
    function automatic logic kind_is_signed(input md_kind_e kind);
        return (kind == MUL) || (kind == DIV);
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath: one shift-add (multiply) or restoring
// subtract (divide, only with MDU_DIV_EN) step per cycle on operand
// magnitudes, followed by a combinational sign fixup of HI/LO.
module mdu_iter
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              start_i,
    input  logic              step_i,
    input  md_kind_e          kind_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              last_o
);

    localparam int CNT_W = $clog2(DATA_W);

    // acc_q: upper half of the product / partial remainder
    // mq_q : multiplier shifting out / dividend shifting out, quotient in
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   mq_q, mq_d;
    logic [DATA_W-1:0]   opb_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                neg_res_q;

    logic                neg1, neg2;
    logic [DATA_W-1:0]   mag1, mag2;
    logic [DATA_W-1:0]   load_mq, load_opb;
    logic [DATA_W-1:0]   addend;
    logic [DATA_W:0]     sum;
    logic [2*DATA_W-1:0] prod;

`ifdef MDU_DIV_EN
    logic                is_div;
    logic                is_div_q, neg_rem_q, div0_q;
    logic [DATA_W:0]     shifted, diff;
`endif

    // Operand magnitudes and register load values for the op being started
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and a latch is inferred.
    always_comb begin
        neg1     = kind_is_signed(kind_i) & src1_i[DATA_W-1];
        neg2     = kind_is_signed(kind_i) & src2_i[DATA_W-1];
        mag1     = neg1 ? -src1_i : src1_i;
        mag2     = neg2 ? -src2_i : src2_i;
        load_mq  = mag2;
        load_opb = mag1;
`ifdef MDU_DIV_EN
        is_div   = (kind_i == DIV) || (kind_i == DIVU);
        if (is_div) begin
            load_mq  = mag1;
            load_opb = mag2;
        end
`endif
    end

    // One iteration step: shift-add by default, restoring subtract for divides
    always_comb begin
        addend = mq_q[0] ? opb_q : '0;
        sum    = {1'b0, acc_q} + {1'b0, addend};
        acc_d  = sum[DATA_W:1];
        mq_d   = {sum[0], mq_q[DATA_W-1:1]};
`ifdef MDU_DIV_EN
        shifted = {acc_q, mq_q[DATA_W-1]};
        diff    = shifted - {1'b0, opb_q};
        if (is_div_q) begin
            acc_d = diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
            mq_d  = {mq_q[DATA_W-2:0], ~diff[DATA_W]};
        end
`endif
    end

    // Operand capture on start, then one step per enabled cycle
    // NOTE: the datapath registers carry no reset; start reloads every one of them and HI/LO are written only from FIX.
    always_ff @(posedge clk_i) begin
        if (start_i) begin
            acc_q     <= '0;
            mq_q      <= load_mq;
            opb_q     <= load_opb;
            cnt_q     <= '0;
            neg_res_q <= neg1 ^ neg2;
`ifdef MDU_DIV_EN
            is_div_q  <= is_div;
            neg_rem_q <= neg1;
            div0_q    <= (src2_i == '0);
`endif
        end else if (step_i) begin
            acc_q <= acc_d;
            mq_q  <= mq_d;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign last_o = (cnt_q == CNT_W'(DATA_W - 1));

    // Sign correction of the finished magnitude result
    always_comb begin
        prod = {acc_q, mq_q};
        if (neg_res_q) begin
            prod = -prod;
        end
        hi_o = prod[2*DATA_W-1:DATA_W];
        lo_o = prod[DATA_W-1:0];
`ifdef MDU_DIV_EN
        if (is_div_q) begin
            lo_o = neg_res_q ? -mq_q : mq_q;
            hi_o = neg_rem_q ? -acc_q : acc_q;
            if (div0_q) begin
                lo_o = '1;
            end
        end
`endif
    end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// MIPS ALU controller: combinational ALUOp/funct decode plus an iterative
// multiply/divide unit with HI/LO registers and pipeline stall.
// Define MDU_DIV_EN to include DIV/DIVU; otherwise they decode as illegal.
module alu_ctrl_mdu
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [2:0]        ALUOp_i,
    input  logic [5:0]        funct_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    output logic [3:0]        ALUCtrl_o,
    output logic              md_stall_o,
    output logic              md_done_o,
    output logic              illegal_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    md_state_e         state_q, state_d;
    logic [3:0]        alu_ctrl;
    logic              illegal, md_op, mf_op;
    md_kind_e          md_kind;
    logic              accept, start, step, fix_wr, last;
    logic [DATA_W-1:0] hi_q, lo_q, md_hi, md_lo;
    logic              done_q;

    // Decode ALUOp/funct into the ALU select and MDU op classification
    always_comb begin
        alu_ctrl = CTRL_AND;
        illegal  = 1'b0;
        md_op    = 1'b0;
        mf_op    = 1'b0;
        md_kind  = MUL;
        case (ALUOp_i)
            ALUOP_MEM, ALUOP_ADDI: alu_ctrl = CTRL_ADD;
            ALUOP_BEQ:             alu_ctrl = CTRL_SUB;
            ALUOP_SLTI:            alu_ctrl = CTRL_SLT;
            ALUOP_J, ALUOP_ANDI:   alu_ctrl = CTRL_AND;
            ALUOP_ORI:             alu_ctrl = CTRL_OR;
            ALUOP_RTYPE: begin
                case (funct_i)
                    FUNCT_ADD:  alu_ctrl = CTRL_ADD;
                    FUNCT_SUB:  alu_ctrl = CTRL_SUB;
                    FUNCT_AND:  alu_ctrl = CTRL_AND;
                    FUNCT_OR:   alu_ctrl = CTRL_OR;
                    FUNCT_NOR:  alu_ctrl = CTRL_NOR;
                    FUNCT_SLT:  alu_ctrl = CTRL_SLT;
                    FUNCT_JR:   alu_ctrl = CTRL_AND;
                    FUNCT_MFHI: begin
                        alu_ctrl = CTRL_MFHI;
                        mf_op    = 1'b1;
                    end
                    FUNCT_MFLO: begin
                        alu_ctrl = CTRL_MFLO;
                        mf_op    = 1'b1;
                    end
                    FUNCT_MULT: begin
                        md_op   = 1'b1;
                        md_kind = MUL;
                    end
                    FUNCT_MULTU: begin
                        md_op   = 1'b1;
                        md_kind = MULU;
                    end
                    FUNCT_DIV, FUNCT_DIVU: begin
`ifdef MDU_DIV_EN
                        md_op = 1'b1;
                        if (funct_i == FUNCT_DIV) begin
                            md_kind = DIV;
                        end else begin
                            md_kind = DIVU;
                        end
`else
                        illegal = 1'b1;
`endif
                    end
                    default: illegal = 1'b1;
                endcase
            end
            default: alu_ctrl = CTRL_AND;
        endcase
    end

    assign ALUCtrl_o  = alu_ctrl;
    assign illegal_o  = valid_i & illegal;
    assign accept     = valid_i & md_op & (state_q == IDLE);
    assign md_stall_o = valid_i & (md_op | mf_op) & (state_q != IDLE);

    // FSM next state and datapath controls
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        step    = 1'b0;
        fix_wr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    start   = 1'b1;
                    state_d = ITER;
                end
            end
            ITER: begin
                step = 1'b1;
                if (last) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                fix_wr  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register; reset aborts any in-flight operation
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // HI/LO registers and the done pulse, written only from FIX
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= fix_wr;
            if (fix_wr) begin
                hi_q <= md_hi;
                lo_q <= md_lo;
            end
        end
    end

    assign hi_o      = hi_q;
    assign lo_o      = lo_q;
    assign md_done_o = done_q;

    mdu_iter #(
        .DATA_W (DATA_W)
    ) u_mdu_iter (
        .clk_i   (clk_i),
        .start_i (start),
        .step_i  (step),
        .kind_i  (md_kind),
        .src1_i  (src1_i),
        .src2_i  (src2_i),
        .hi_o    (md_hi),
        .lo_o    (md_lo),
        .last_o  (last)
    );

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Scoreboard bench for alu_ctrl_mdu. Divide expectations follow MDU_DIV_EN.
module tb_alu_ctrl_mdu;

    localparam int W   = 32;
    localparam int LAT = W + 1;  // edges from accept edge to the HI/LO write

    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_SLT  = 4'b0111;
    localparam logic [3:0] C_NOR  = 4'b1100;
    localparam logic [3:0] C_MFHI = 4'b1000;
    localparam logic [3:0] C_MFLO = 4'b1001;

    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_ADD   = 6'h20;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          valid_i = 1'b0;
    logic [2:0]    ALUOp_i = '0;
    logic [5:0]    funct_i = '0;
    logic [W-1:0]  src1_i = '0;
    logic [W-1:0]  src2_i = '0;
    logic [3:0]    ALUCtrl_o;
    logic          md_stall_o, md_done_o, illegal_o;
    logic [W-1:0]  hi_o, lo_o;

    alu_ctrl_mdu #(.DATA_W(W)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .ALUOp_i    (ALUOp_i),
        .funct_i    (funct_i),
        .src1_i     (src1_i),
        .src2_i     (src2_i),
        .ALUCtrl_o  (ALUCtrl_o),
        .md_stall_o (md_stall_o),
        .md_done_o  (md_done_o),
        .illegal_o  (illegal_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           done_cyc;
    } exp_t;

    exp_t         sb_q[$];
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    int           busy_from = 0;
    int           busy_to = -1;
    logic         accepted = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Decode reference taken straight from the opcode tables
    function automatic void ref_decode(input logic [2:0] op, input logic [5:0] f,
                                       output logic [3:0] c, output logic ill,
                                       output logic md, output logic mf);
        c = C_AND; ill = 1'b0; md = 1'b0; mf = 1'b0;
        case (op)
            3'd0, 3'd3: c = C_ADD;
            3'd1:       c = C_SUB;
            3'd4:       c = C_SLT;
            3'd7:       c = C_OR;
            3'd2: begin
                case (f)
                    6'h20: c = C_ADD;
                    6'h22: c = C_SUB;
                    6'h24: c = C_AND;
                    6'h25: c = C_OR;
                    6'h27: c = C_NOR;
                    6'h2A: c = C_SLT;
                    6'h08: c = C_AND;
                    6'h10: begin c = C_MFHI; mf = 1'b1; end
                    6'h12: begin c = C_MFLO; mf = 1'b1; end
                    6'h18, 6'h19: md = 1'b1;
`ifdef MDU_DIV_EN
                    6'h1A, 6'h1B: md = 1'b1;
`else
                    6'h1A, 6'h1B: ill = 1'b1;
`endif
                    default: ill = 1'b1;
                endcase
            end
            default: c = C_AND;
        endcase
    endfunction

    // Arithmetic reference: returns {HI, LO}
    function automatic logic [63:0] ref_md(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f)
            F_MULT:  res = sa * sb;
            F_MULTU: res = ua * ub;
            default: begin
                if (b == '0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else if (f == F_DIV) begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end else begin
                    res = {ua[31:0] % ub[31:0], ua[31:0] / ub[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    // Monitor: pops on md_done_o and tracks HI/LO every cycle
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_i) begin
            if (md_done_o) begin
                if (sb_q.size() == 0) begin
                    check("unexpected md_done_o", {63'b0, md_done_o}, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("md_done_o cycle", cyc, e.done_cyc);
                    m_hi = e.hi;
                    m_lo = e.lo;
                end
            end
            check("hi_o", hi_o, m_hi);
            check("lo_o", lo_o, m_lo);
        end
    end

    // One cycle of stimulus, entered and left at posedge+1
    task automatic step(input logic v, input logic [2:0] op, input logic [5:0] f,
                        input logic [W-1:0] a, input logic [W-1:0] b);
        logic [3:0]  e_c;
        logic        e_ill, e_md, e_mf, e_stall;
        logic [63:0] r;
        exp_t        e;
        valid_i = v; ALUOp_i = op; funct_i = f; src1_i = a; src2_i = b;
        ref_decode(op, f, e_c, e_ill, e_md, e_mf);
        @(negedge clk_i);
        e_stall = v && (e_md || e_mf) && (busy_from <= cyc) && (cyc <= busy_to);
        check("ALUCtrl_o", ALUCtrl_o, e_c);
        check("illegal_o", illegal_o, v & e_ill);
        check("md_stall_o", md_stall_o, e_stall);
        accepted = v && e_md && !e_stall;
        if (accepted) begin
            r = ref_md(f, a, b);
            busy_from = cyc + 1;
            busy_to   = cyc + 1 + W;
            e.hi = r[63:32];
            e.lo = r[31:0];
            e.done_cyc = cyc + 1 + LAT;
            sb_q.push_back(e);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 6'd0, '0, '0);
    endtask

    // Present an R-type op until accepted (MD ops) or for one cycle (others)
    task automatic md(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [3:0] c;
        logic il, m, mf;
        ref_decode(3'd2, f, c, il, m, mf);
        if (!m) begin
            step(1'b1, 3'd2, f, a, b);
            return;
        end
        for (int i = 0; i < W + 8; i++) begin
            step(1'b1, 3'd2, f, a, b);
            if (accepted) return;
        end
        check("accept timeout", {63'b0, accepted}, 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 3 * W; i++) begin
            if (sb_q.size() == 0 && cyc > busy_to) return;
            step(1'b0, 3'd0, 6'd0, '0, '0);
        end
        check("drain timeout", sb_q.size(), 64'd0);
    endtask

    function automatic logic [W-1:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return W'($urandom_range(0, 9));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        logic [5:0] alu_functs[10];
        logic [5:0] rnd_functs[16];
        alu_functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h08, 6'h10, 6'h12, 6'h3F};
        rnd_functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h08, 6'h10,
                       6'h12, 6'h3F, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h00, 6'h2B};

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        check("reset hi_o", hi_o, 64'd0);
        check("reset lo_o", lo_o, 64'd0);
        check("reset md_done_o", {63'b0, md_done_o}, 64'd0);
        check("reset md_stall_o", {63'b0, md_stall_o}, 64'd0);
        rst_i = 1'b1;

        // Decode sweep
        for (int op = 0; op < 8; op++) begin
            if (op != 2) step(1'b1, 3'(op), 6'($urandom), '0, '0);
        end
        foreach (alu_functs[i]) step(1'b1, 3'd2, alu_functs[i], '0, '0);
        step(1'b0, 3'd2, 6'h3F, '0, '0);

        // Multiply directed cases
        md(F_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
        drain();
        check("MULT hi", hi_o, 64'hFFFF_FFFF);
        check("MULT lo", lo_o, 64'hFFFF_FFFA);
        md(F_MULTU, 32'hFFFF_FFFE, 32'h0000_0003);
        drain();
        check("MULTU hi", hi_o, 64'h0000_0002);
        check("MULTU lo", lo_o, 64'hFFFF_FFFA);

`ifdef MDU_DIV_EN
        md(F_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        drain();
        check("DIV -7/2 lo", lo_o, 64'hFFFF_FFFD);
        check("DIV -7/2 hi", hi_o, 64'hFFFF_FFFF);
        md(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        drain();
        check("DIV min/-1 lo", lo_o, 64'h8000_0000);
        check("DIV min/-1 hi", hi_o, 64'd0);
        md(F_DIVU, 32'd5, 32'd0);
        drain();
        check("DIVU 5/0 lo", lo_o, 64'hFFFF_FFFF);
        check("DIVU 5/0 hi", hi_o, 64'd5);
`else
        md(F_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        md(F_DIVU, 32'd5, 32'd0);
        drain();
        check("no-div hi kept", hi_o, 64'h0000_0002);
        check("no-div lo kept", lo_o, 64'hFFFF_FFFA);
`endif

        // Stall window: MFLO held off until FIX completes, ADD never stalls
        md(F_MULT, 32'd1234, 32'hFFFF_FF00);
        for (int k = 0; k < W + 4; k++) begin
            if (k == 5 || k == W) step(1'b1, 3'd2, F_ADD, '0, '0);
            else if (k == 7) md(F_DIV, 32'd9, 32'd3);
            else step(1'b1, 3'd2, F_MFLO, '0, '0);
        end
        drain();

        // Back-to-back MD ops
        md(F_MULT, 32'd100, 32'd200);
        md(F_MULTU, 32'hDEAD_BEEF, 32'h1234_5678);
        drain();

        // Reset in the middle of an operation
        md(F_MULT, 32'hCAFE_F00D, 32'h0BAD_BEEF);
        idle(9);
        rst_i = 1'b0;
        valid_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        sb_q.delete();
        m_hi = '0;
        m_lo = '0;
        busy_from = 0;
        busy_to = -1;
        check("abort hi_o", hi_o, 64'd0);
        check("abort lo_o", lo_o, 64'd0);
        idle(W + 4);
        md(F_MULT, 32'd6, 32'd7);
        drain();
        check("MULT 6x7 lo", lo_o, 64'd42);
        check("MULT 6x7 hi", hi_o, 64'd0);

        // Randomized traffic
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 9) < 4) begin
                md(6'h18 + 6'($urandom_range(0, 3)), rand_opnd(), rand_opnd());
            end else begin
                step(1'($urandom), 3'($urandom), rnd_functs[$urandom_range(0, 15)], rand_opnd(), rand_opnd());
            end
            idle($urandom_range(0, 3));
        end
        drain();
        check("scoreboard empty", sb_q.size(), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_ctrl_mdu.md
# alu_ctrl_mdu

Parametrised ALU controller for the MIPS datapath, extending the ALUOp/funct decode with an iterative multiply/divide unit (MDU) and HI/LO registers. It sits between the main Decoder and the ALU/writeback mux. Standard ops decode combinationally. MULT/MULTU/DIV/DIVU start a multi-cycle sequence, and the block raises a stall to the pipeline until the HI/LO results are ready.

## Interface
- DATA_W, 32, operand and HI/LO width (even, ≥8)
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-low
- valid_i  in  1  decode-stage instruction valid
- ALUOp_i  in  3  ALU operation class from Decoder
- funct_i  in  6  R-type funct field
- src1_i  in  DATA_W  rs operand (multiplicand / dividend)
- src2_i  in  DATA_W  rt operand (multiplier / divisor)
- ALUCtrl_o  out  4  ALU operation select
- md_stall_o  out  1  hold pipeline this cycle
- md_done_o  out  1  one-cycle pulse when HI/LO are written
- illegal_o  out  1  unrecognised ALUOp/funct combination
- hi_o, lo_o  out  DATA_W  HI/LO register contents

## Operation
- ALUCtrl codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100, MFHI 1000, MFLO 1001. The ALU result mux selects hi_o/lo_o on MFHI/MFLO.
- ALUOp decode:
  - 0 (LW/SW) → ADD; 1 (BEQ) → SUB; 3 (ADDI) → ADD; 4 (SLTI) → SLT; 5 (J) → AND; 6 (ANDI) → AND; 7 (ORI) → OR.
  - 2 (R-type) decodes funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT, 001000 JR → AND, 010000 MFHI, 010010 MFLO.
  - Funct 011000/011001/011010/011011 (MULT/MULTU/DIV/DIVU) are MD ops; ALUCtrl_o = AND for these.
  - Unlisted funct → ALUCtrl_o = 0000 and illegal_o = valid_i.
- ALUCtrl_o and illegal_o are purely combinational from their inputs.
- FSM states:
  - IDLE → ITER on accept, i.e. valid_i & MD op & state==IDLE. Operands, signedness and op kind are latched on accept.
  - ITER runs DATA_W cycles: one shift-add step (mul) or restoring subtract step (div) per cycle, on operand magnitudes.
  - ITER → FIX after the last step. FIX applies the sign correction and writes HI/LO.
  - FIX → IDLE.
- Mul result: HI = upper DATA_W bits of the product, LO = lower DATA_W bits. Signed MULT is two's-complement.
- Div result: LO = quotient, HI = remainder. The remainder takes the sign of the dividend. Quotient truncates toward zero.
- Divide by zero: LO = all ones, HI = dividend, with no trap.
- Signed INT_MIN / −1: LO = INT_MIN, HI = 0.
- Stall: md_stall_o = valid_i & (MD op | MFHI | MFLO) & state≠IDLE. A stalled instruction is not accepted and must be re-presented.
- ALU-only instructions never stall, even while the MDU is busy.

## Timing
- Reset (rst_i low at a clock edge): state = IDLE, hi_o = lo_o = 0, md_done_o = 0. Any in-flight operation is aborted without writing HI/LO.
- An op accepted at edge T is in ITER for edges T+1..T+DATA_W and in FIX at T+DATA_W+1.
- md_done_o is high for the cycle following edge T+DATA_W+1. HI/LO hold their new values from that same cycle.
- Total latency is DATA_W+2 cycles; with DATA_W=32, results are visible 34 cycles after accept.
- A back-to-back MD op presented during FIX stalls. It is accepted on the first IDLE cycle.
- hi_o and lo_o are unchanged except on a FIX write or reset.

## Configuration
- MDU_DIV_EN defined: DIV/DIVU are supported as described above.
- MDU_DIV_EN undefined:
  - The divide datapath and its step logic are removed.
  - DIV/DIVU assert illegal_o, are never accepted, never stall, and leave HI/LO unchanged.
  - MULT/MULTU behaviour is identical to the defined case.

## Structure
- Package alu_ctrl_pkg holds:
  - ALUOp encodings, funct constants and ALUCtrl codes;
  - the FSM state typedef (IDLE, ITER, FIX);
  - the MD op-kind typedef (MUL, MULU, DIV, DIVU).
- Sub-module mdu_iter contains the iteration datapath: accumulator, shift registers, step counter and sign fixup. It takes start/kind/operands and returns hi/lo/last. The top level owns decode, the FSM, the stall logic and the HI/LO registers.

## Test plan
- Decode sweep: every ALUOp value and every listed funct → the ALUCtrl_o code above. funct 111111 with valid_i=1 → illegal_o=1, ALUCtrl_o=0000.
- MULT: src1=0xFFFFFFFE (−2), src2=0x00000003 → after 34 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFA, md_done_o a single pulse. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV: src1=0xFFFFFFF9 (−7), src2=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. DIVU 5/0 → LO=0xFFFFFFFF, HI=5.
- Stall: issue MULT, then present MFLO on the next cycle → md_stall_o=1 until FIX completes. An intervening ADD → md_stall_o=0.
- Reset mid-op: rst_i low at ITER cycle 10 → state IDLE, HI=LO=0, no md_done_o. A new MULT 6×7 → LO=42, HI=0.
- Build without MDU_DIV_EN: DIV presented → illegal_o=1, md_stall_o=0, HI/LO unchanged.
